// File: rtl/clk_div_sequencer_pkg.sv
// Shared types and helpers for the clock-divide sequencer: FSM state encoding,
// minimum legal ratio and the high-phase length of a divide ratio.
package clk_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, SWITCH, STOPPING} state_t;

   localparam int DIV_MIN = 2;

   // High phase is the floor half, so odd ratios spend the extra cycle low
   function automatic logic [31:0] hi_len(input logic [31:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clk_div_sequencer_if.sv
// Ratio configuration handshake between software/config logic and the sequencer.
interface clk_div_sequencer_if #(parameter int CNT_W = 8);

   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
   modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/clk_div_sequencer_core.sv
// Divide-by-N engine: period counter, active ratio and the registered clk_out/clk_en.
// The sequencer decides when it runs and when a new ratio is loaded.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             i_run,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_div,
   output logic             o_at_boundary,
   output logic [CNT_W-1:0] o_cur_div,
   output logic             o_clk_out,
   output logic             o_clk_en
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_cur_div;
   logic             r_clk_out;
   logic             r_clk_en;
   logic             r_running;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_hi;
   logic             w_at_boundary;
   logic             w_clk_out_next;

   assign w_hi          = CNT_W'(hi_len(32'(r_cur_div)));
   assign w_at_boundary = (r_cnt == (r_cur_div - ONE));

   // First running cycle starts at 0 so clk_out rises one edge after start
   always_comb begin
      w_cnt_next = '0;
      if (i_run && r_running && !w_at_boundary) begin
         w_cnt_next = r_cnt + ONE;
      end
      w_clk_out_next = i_run && (w_cnt_next < w_hi);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_cur_div <= CNT_W'(DEFAULT_DIV);
         r_clk_out <= 1'b0;
         r_clk_en  <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_clk_out <= w_clk_out_next;
         r_clk_en  <= w_clk_out_next & ~r_clk_out;
         r_running <= i_run;
         if (i_load) begin
            r_cur_div <= i_load_div;
         end
      end
   end

   assign o_at_boundary = w_at_boundary;
   assign o_cur_div     = r_cur_div;
   assign o_clk_out     = r_clk_out;
   assign o_clk_en      = r_clk_en;

endmodule

// File: rtl/clk_div_sequencer.sv
// Run-time controller for the fabric clock divider: sequences start, stop and
// ratio changes so every change lands on a period boundary and clk_out never runts.
module clk_div_sequencer
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  i_run_en,
   clk_div_sequencer_if.slave    cfg,
   output logic                  o_clk_out,
   output logic                  o_clk_en,
   output logic [CNT_W-1:0]      o_cur_div,
   output logic                  o_busy
);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_shadow;
   logic             r_cfg_err;
   logic             w_ready;
   logic             w_accept;
   logic             w_legal;
   logic             w_load;
   logic [CNT_W-1:0] w_load_div;
   logic             w_at_boundary;
   logic             w_run;

   assign w_ready  = (r_state == IDLE) || (r_state == RUN);
   assign w_accept = cfg.cfg_valid && w_ready;
   assign w_legal  = (cfg.cfg_div >= CNT_W'(DIV_MIN));
   assign w_run    = (w_state_next != IDLE);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A stop requested together with a ratio write is resolved at the switch boundary
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_div   = r_shadow;
      case (r_state)
         IDLE: begin
            if (w_accept && w_legal) begin
               w_load     = 1'b1;
               w_load_div = cfg.cfg_div;
            end
            if (i_run_en) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (w_accept && w_legal) begin
               w_state_next = SWITCH;
            end else if (!i_run_en) begin
               w_state_next = STOPPING;
            end
         end
         SWITCH: begin
            if (w_at_boundary) begin
               w_load       = 1'b1;
               w_state_next = i_run_en ? RUN : IDLE;
            end
         end
         STOPPING: begin
            if (i_run_en) begin
               w_state_next = RUN;
            end else if (w_at_boundary) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_shadow  <= CNT_W'(DEFAULT_DIV);
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_accept && !w_legal;
         if ((r_state == RUN) && w_accept && w_legal) begin
            r_shadow <= cfg.cfg_div;
         end
      end
   end

   clk_div_core #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_core (
      .clk_in        (clk_in),
      .reset         (reset),
      .i_run         (w_run),
      .i_load        (w_load),
      .i_load_div    (w_load_div),
      .o_at_boundary (w_at_boundary),
      .o_cur_div     (o_cur_div),
      .o_clk_out     (o_clk_out),
      .o_clk_en      (o_clk_en)
   );

   assign cfg.cfg_ready = w_ready;
   assign cfg.cfg_err   = r_cfg_err;
   assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Self-checking bench for clk_div_sequencer: a per-cycle vector table for start,
// ratio switches, illegal writes and stops, plus hand sequences for N=255 and async reset.
module tb_clk_div_sequencer;

   typedef struct {
      logic        runEn;
      logic        cfgValid;
      logic [7:0]  cfgDiv;
      logic [12:0] expOut;
   } vec_t;

   logic       clkIn;
   logic       reset;
   logic       runEn;
   logic       clkOut;
   logic       clkEn;
   logic [7:0] curDiv;
   logic       busy;

   int nChecks = 0;
   int nPass   = 0;

   vec_t vecs[$];

   clk_div_sequencer_if #(.CNT_W(8)) cfgIf ();

   clk_div_sequencer #(
      .CNT_W       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .clk_in    (clkIn),
      .reset     (reset),
      .i_run_en  (runEn),
      .cfg       (cfgIf.slave),
      .o_clk_out (clkOut),
      .o_clk_en  (clkEn),
      .o_cur_div (curDiv),
      .o_busy    (busy)
   );

   // 10-unit clock period, rising edges at 5, 15, 25 ...
   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   function automatic logic [12:0] outBundle();
      return {clkOut, clkEn, cfgIf.cfg_ready, cfgIf.cfg_err, curDiv, busy};
   endfunction

   // Bundle layout: {clk_out, clk_en, cfg_ready, cfg_err, cur_div[7:0], busy}
   task automatic addVec(input logic r, input logic v, input logic [7:0] d,
                         input logic co, input logic ce, input logic rdy,
                         input logic err, input logic [7:0] cdiv, input logic bsy);
      vec_t t;
      t.runEn    = r;
      t.cfgValid = v;
      t.cfgDiv   = d;
      t.expOut   = {co, ce, rdy, err, cdiv, bsy};
      vecs.push_back(t);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs away from the active edge, then sample just after it
   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
      @(negedge clkIn);
      runEn           = r;
      cfgIf.cfg_valid = v;
      cfgIf.cfg_div   = d;
      @(posedge clkIn);
      #1;
   endtask

   task automatic pulseReset();
      @(negedge clkIn);
      runEn           = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      reset           = 1'b1;
      @(negedge clkIn);
      reset = 1'b0;
   endtask

   initial begin
      int firstCe;
      int lastCe;
      int pulses;
      int highCnt;

      reset           = 1'b1;
      runEn           = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      cfgIf.cfg_div   = 8'd0;
      #12;
      checkOutput("reset_state", 32'(outBundle()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0}));
      @(negedge clkIn);
      reset = 1'b0;

      // N=4 start: first rise one edge after run_en, 2 high / 2 low
      addVec(1,0,0,   1,1,1,0,  4,1);
      addVec(1,1,6,   1,0,0,0,  4,1);
      addVec(1,0,0,   0,0,0,0,  4,1);
      addVec(1,0,0,   0,0,0,0,  4,1);
      // Switch to 6 at the boundary, then 3 high / 3 low
      addVec(1,0,0,   1,1,1,0,  6,1);
      addVec(1,0,0,   1,0,1,0,  6,1);
      addVec(1,0,0,   1,0,1,0,  6,1);
      addVec(1,0,0,   0,0,1,0,  6,1);
      addVec(1,0,0,   0,0,1,0,  6,1);
      addVec(1,0,0,   0,0,1,0,  6,1);
      addVec(1,0,0,   1,1,1,0,  6,1);
      // Switch to 5: 2 high / 3 low
      addVec(1,1,5,   1,0,0,0,  6,1);
      addVec(1,0,0,   1,0,0,0,  6,1);
      addVec(1,0,0,   0,0,0,0,  6,1);
      addVec(1,0,0,   0,0,0,0,  6,1);
      addVec(1,0,0,   0,0,0,0,  6,1);
      addVec(1,0,0,   1,1,1,0,  5,1);
      addVec(1,0,0,   1,0,1,0,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   1,1,1,0,  5,1);
      // Illegal ratios 1 and 0: error pulse only, waveform unchanged
      addVec(1,1,1,   1,0,1,1,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,1,0,   0,0,1,1,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   1,1,1,0,  5,1);
      // Stop in the first high cycle, finish the period, go idle
      addVec(0,0,0,   1,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,1,0,  5,0);
      addVec(0,0,0,   0,0,1,0,  5,0);
      // Restart, stop, re-raise during STOPPING: continuous period of 5
      addVec(1,0,0,   1,1,1,0,  5,1);
      addVec(0,0,0,   1,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   0,0,1,0,  5,1);
      addVec(1,0,0,   1,1,1,0,  5,1);
      // Rewrite the same ratio: SWITCH path, identical waveform
      addVec(1,1,5,   1,0,0,0,  5,1);
      addVec(1,0,0,   0,0,0,0,  5,1);
      addVec(1,0,0,   0,0,0,0,  5,1);
      addVec(1,0,0,   0,0,0,0,  5,1);
      addVec(1,0,0,   1,1,1,0,  5,1);
      // Write and stop together: new ratio applied, then idle at that boundary
      addVec(0,1,2,   1,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,0,0,  5,1);
      addVec(0,0,0,   0,0,1,0,  2,0);
      // Writes in IDLE load immediately; illegal one is dropped
      addVec(0,1,255, 0,0,1,0,255,0);
      addVec(0,1,0,   0,0,1,1,255,0);
      addVec(0,0,0,   0,0,1,0,255,0);
      addVec(0,1,2,   0,0,1,0,  2,0);
      // Minimum ratio 2: 1 high / 1 low
      addVec(1,0,0,   1,1,1,0,  2,1);
      addVec(1,0,0,   0,0,1,0,  2,1);
      addVec(1,0,0,   1,1,1,0,  2,1);
      addVec(1,0,0,   0,0,1,0,  2,1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].runEn, vecs[i].cfgValid, vecs[i].cfgDiv);
         checkOutput($sformatf("vec%0d", i + 1), 32'(outBundle()), 32'(vecs[i].expOut));
      end

      // Largest ratio 255: period 255, 127 high cycles
      pulseReset();
      applyStimulus(1'b0, 1'b1, 8'd255);
      checkOutput("idle_load_255", 32'(curDiv), 32'd255);
      firstCe = -1;
      lastCe  = -1;
      pulses  = 0;
      highCnt = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         applyStimulus(1'b1, 1'b0, 8'd0);
         if (clkEn) begin
            pulses++;
            if (pulses == 1) firstCe = cyc;
            if (pulses == 2) lastCe = cyc;
         end
         if (pulses == 1 && clkOut) highCnt++;
         if (pulses == 2) break;
      end
      checkOutput("n255_pulses_seen", 32'(pulses), 32'd2);
      checkOutput("n255_first_rise", 32'(firstCe), 32'd0);
      checkOutput("n255_period", 32'(lastCe - firstCe), 32'd255);
      checkOutput("n255_high_cycles", 32'(highCnt), 32'd127);

      // Reset while clk_out is high, between clock edges
      checkOutput("pre_reset_high", 32'(clkOut), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_clk_out", 32'({clkOut, clkEn}), 32'd0);
      runEn = 1'b0;
      @(negedge clkIn);
      reset = 1'b0;
      #1;
      checkOutput("post_reset_state", 32'(outBundle()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0}));
      applyStimulus(1'b1, 1'b0, 8'd0);
      checkOutput("restart_after_reset", 32'({clkOut, clkEn, busy}), 32'b111);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
